// File: rtl/int_seq_pkg.sv
// Shared types and constants for the 6502 interrupt entry sequencer.
package int_seq_pkg;

  localparam int unsigned STEP_W = 3;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_RES  = 3'd1,
    SRC_NMI  = 3'd2,
    SRC_IRQ  = 3'd3,
    SRC_BRK  = 3'd4
  } src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  localparam logic [STEP_W-1:0] T0 = 3'd0;
  localparam logic [STEP_W-1:0] T1 = 3'd1;
  localparam logic [STEP_W-1:0] T2 = 3'd2;
  localparam logic [STEP_W-1:0] T3 = 3'd3;
  localparam logic [STEP_W-1:0] T4 = 3'd4;
  localparam logic [STEP_W-1:0] T5 = 3'd5;
  localparam logic [STEP_W-1:0] T6 = 3'd6;

  localparam logic [ADDR_W-1:0] DEF_VEC_NMI = 16'hFFFA;
  localparam logic [ADDR_W-1:0] DEF_VEC_RES = 16'hFFFC;
  localparam logic [ADDR_W-1:0] DEF_VEC_IRQ = 16'hFFFE;

  // Steps T2..T4 are the stack write cycles.
  function automatic logic is_push(input logic [STEP_W-1:0] s);
    return (s == T2) || (s == T3) || (s == T4);
  endfunction

endpackage

// File: rtl/interrupt_sequencer_edge_sync.sv
// Multi-flop synchroniser for an async active-low pin, with a falling-edge pulse.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;

  // Pins idle high, so the chain resets to 1 and no edge is seen out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_last <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_last <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_fall  = r_last & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Detects reset/NMI/IRQ/BRK, forces BRK at instruction boundaries and steps
// the 7-cycle interrupt entry sequence for the decoder and register file.
module interrupt_sequencer
  import int_seq_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [15:0]      VEC_NMI     = DEF_VEC_NMI,
  parameter logic [15:0]      VEC_RES     = DEF_VEC_RES,
  parameter logic [15:0]      VEC_IRQ     = DEF_VEC_IRQ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        sync,
  input  logic        brk_op,
  output logic        busy,
  output logic        force_brk,
  output logic [2:0]  step,
  output logic        push_pch,
  output logic        push_pcl,
  output logic        push_p,
  output logic        rw,
  output logic        b_flag,
  output logic        vec_lo,
  output logic        vec_hi,
  output logic [15:0] vector,
  output logic        set_i,
  output logic        nmi_ack
);

  state_e              r_state, w_state_nxt;
  src_e                r_src, w_src_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic                r_res_pend, w_res_pend_nxt;
  logic                r_nmi_pend, w_nmi_pend_nxt;
  logic [ADDR_W-1:0]   r_vector, w_vector_nxt;
  logic                r_b_flag, w_b_flag_nxt;
  logic                r_set_i, w_set_i_nxt;
  logic                r_nmi_ack, w_nmi_ack_nxt;

  logic w_force_brk;
  logic w_nmi_fall, w_nmi_level_unused;
  logic w_irq_level, w_irq_fall_unused;
  logic w_nmi_hit, w_irq_q, w_busy, w_push, w_advance, w_hijack_ok;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (nmi_n),
    .o_level (w_nmi_level_unused),
    .o_fall  (w_nmi_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (irq_n),
    .o_level (w_irq_level),
    .o_fall  (w_irq_fall_unused)
  );

  // A same-cycle edge counts as pending so NMI beats IRQ on a shared boundary.
  assign w_nmi_hit   = r_nmi_pend | w_nmi_fall;
  assign w_irq_q     = ~w_irq_level & ~i_flag;
  assign w_busy      = (r_state == ST_SEQ);
  assign w_push      = w_busy && is_push(r_step);
  assign w_advance   = rdy | w_push;
  assign w_hijack_ok = ((r_src == SRC_IRQ) || (r_src == SRC_BRK)) && (r_step <= T4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_src      <= SRC_NONE;
      r_step     <= T0;
      r_res_pend <= 1'b1;
      r_nmi_pend <= 1'b0;
      r_vector   <= VEC_RES;
      r_b_flag   <= 1'b0;
      r_set_i    <= 1'b0;
      r_nmi_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_step     <= w_step_nxt;
      r_res_pend <= w_res_pend_nxt;
      r_nmi_pend <= w_nmi_pend_nxt;
      r_vector   <= w_vector_nxt;
      r_b_flag   <= w_b_flag_nxt;
      r_set_i    <= w_set_i_nxt;
      r_nmi_ack  <= w_nmi_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_step_nxt     = r_step;
    w_res_pend_nxt = r_res_pend;
    w_nmi_pend_nxt = r_nmi_pend | w_nmi_fall;
    w_vector_nxt   = r_vector;
    w_b_flag_nxt   = r_b_flag;
    w_set_i_nxt    = 1'b0;
    w_nmi_ack_nxt  = 1'b0;
    w_force_brk    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (sync && rdy && (r_res_pend || w_nmi_hit || w_irq_q)) begin
          w_force_brk  = 1'b1;
          w_state_nxt  = ST_SEQ;
          w_step_nxt   = T1;
          w_b_flag_nxt = 1'b0;
          if (r_res_pend) begin
            w_src_nxt    = SRC_RES;
            w_vector_nxt = VEC_RES;
          end else if (w_nmi_hit) begin
            w_src_nxt    = SRC_NMI;
            w_vector_nxt = VEC_NMI;
          end else begin
            w_src_nxt    = SRC_IRQ;
            w_vector_nxt = VEC_IRQ;
          end
        end else if (brk_op) begin
          // Decoder already spent T1 fetching the BRK opcode.
          w_state_nxt  = ST_SEQ;
          w_src_nxt    = SRC_BRK;
          w_step_nxt   = T2;
          w_vector_nxt = VEC_IRQ;
          w_b_flag_nxt = 1'b1;
        end
      end

      ST_SEQ: begin
        if (w_hijack_ok && w_nmi_hit) begin
          w_src_nxt    = SRC_NMI;
          w_vector_nxt = VEC_NMI;
        end
        if (w_advance) begin
          if (r_step == T6) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = T0;
            w_set_i_nxt = 1'b1;
            if (r_src == SRC_RES) w_res_pend_nxt = 1'b0;
            if (w_src_nxt == SRC_NMI) begin
              w_nmi_pend_nxt = w_nmi_fall;
              w_nmi_ack_nxt  = 1'b1;
            end
          end else begin
            w_step_nxt = r_step + 3'd1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = w_busy;
  assign force_brk = w_force_brk;
  assign step      = r_step;
  assign push_pch  = w_busy && (r_step == T2);
  assign push_pcl  = w_busy && (r_step == T3);
  assign push_p    = w_busy && (r_step == T4);
  assign rw        = ~(w_push && (r_src != SRC_RES));
  assign b_flag    = r_b_flag;
  assign vec_lo    = w_busy && (r_step == T5);
  assign vec_hi    = w_busy && (r_step == T6);
  assign vector    = r_vector;
  assign set_i     = r_set_i;
  assign nmi_ack   = r_nmi_ack;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: each scenario queues its expected
// entry sequence and the collector compares what the sequencer actually stepped.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic        i_flag = 1'b1;
  logic        sync = 1'b0;
  logic        brk_op = 1'b0;
  logic        busy, force_brk, push_pch, push_pcl, push_p, rw, b_flag;
  logic        vec_lo, vec_hi, set_i, nmi_ack;
  logic [2:0]  step;
  logic [15:0] vector;

  typedef struct {
    logic [15:0] vec;
    logic        bf;
    logic        rw;
    int          first;
    int          nack;
  } exp_t;

  exp_t sb_q[$];
  int   trace[$];
  int   checks = 0;
  int   failures = 0;

  interrupt_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .nmi_n(nmi_n), .irq_n(irq_n),
    .i_flag(i_flag), .sync(sync), .brk_op(brk_op), .busy(busy),
    .force_brk(force_brk), .step(step), .push_pch(push_pch),
    .push_pcl(push_pcl), .push_p(push_p), .rw(rw), .b_flag(b_flag),
    .vec_lo(vec_lo), .vec_hi(vec_hi), .vector(vector), .set_i(set_i),
    .nmi_ack(nmi_ack)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Follows one entry sequence to completion, then pops and compares its expectation.
  task automatic collect_seq(input int hold_step, input int hold_n);
    exp_t        e;
    int          waited, npush, nack, first, hold_left;
    bit          held, bad_rw;
    logic        rw_and, rw_or, bf_seen;
    logic [15:0] vlo, vhi;
    waited = 0; npush = 0; nack = 0; hold_left = 0; held = 0; bad_rw = 0;
    rw_and = 1'b1; rw_or = 1'b0; bf_seen = 1'bx; vlo = 16'h0; vhi = 16'h0;
    trace.delete();
    while (!busy && waited < 20) begin cyc(); waited++; end
    checks++;
    if (!busy) begin
      failures++;
      $display("FAIL seq_start busy got=%b exp=1 (timeout)", busy);
      return;
    end
    first = int'(step);
    while (busy && waited < 100) begin
      trace.push_back(int'(step));
      if (push_pch | push_pcl | push_p) begin
        npush++; rw_and &= rw; rw_or |= rw;
      end else if (!rw) bad_rw = 1;
      if (push_p) bf_seen = b_flag;
      if (vec_lo) vlo = vector;
      if (vec_hi) vhi = vector;
      nack += int'(nmi_ack);
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) rdy = 1'b1;
      end else if (!held && int'(step) == hold_step) begin
        held = 1; hold_left = hold_n; rdy = 1'b0;
      end
      cyc(); waited++;
    end
    rdy = 1'b1;
    checks++;
    if (busy) begin failures++; $display("FAIL seq_end busy got=%b exp=0 (timeout)", busy); end
    checks++;
    if (set_i !== 1'b1) begin failures++; $display("FAIL set_i got=%b exp=1", set_i); end
    nack += int'(nmi_ack);
    cyc();
    nack += int'(nmi_ack);
    checks++;
    if (sb_q.size() == 0) begin failures++; $display("FAIL sb_empty got=0 exp=1 entries"); return; end
    e = sb_q.pop_front();
    checks++;
    if (first != e.first) begin failures++; $display("FAIL first_step got=%0d exp=%0d", first, e.first); end
    checks++;
    if (vlo !== e.vec) begin failures++; $display("FAIL vector_t5 got=%h exp=%h", vlo, e.vec); end
    checks++;
    if (vhi !== e.vec) begin failures++; $display("FAIL vector_t6 got=%h exp=%h", vhi, e.vec); end
    checks++;
    if (bf_seen !== e.bf) begin failures++; $display("FAIL b_flag got=%b exp=%b", bf_seen, e.bf); end
    checks++;
    if (rw_and !== e.rw || rw_or !== e.rw) begin
      failures++; $display("FAIL push_rw got=and%b/or%b exp=%b", rw_and, rw_or, e.rw);
    end
    checks++;
    if (npush != 3) begin failures++; $display("FAIL push_count got=%0d exp=3", npush); end
    checks++;
    if (bad_rw) begin failures++; $display("FAIL rw_nonpush got=0 exp=1"); end
    checks++;
    if (nack != e.nack) begin failures++; $display("FAIL nmi_ack_count got=%0d exp=%0d", nack, e.nack); end
    checks++;
    if (trace.size() == 0 || trace[trace.size()-1] != 6) begin
      failures++; $display("FAIL last_step got=%0d exp=6", trace.size() == 0 ? -1 : trace[trace.size()-1]);
    end
  endtask

  task automatic push_exp(input logic [15:0] v, input logic bf, input logic rwv,
                          input int first, input int nack);
    exp_t e;
    e.vec = v; e.bf = bf; e.rw = rwv; e.first = first; e.nack = nack;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (busy !== 1'b0 || step !== 3'd0 || rw !== 1'b1) begin
      failures++; $display("FAIL reset_ctrl got=busy%b/step%0d/rw%b exp=0/0/1", busy, step, rw);
    end
    checks++;
    if ({push_pch, push_pcl, push_p, vec_lo, vec_hi, set_i, nmi_ack, force_brk} !== 8'h00) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000000",
                           {push_pch, push_pcl, push_p, vec_lo, vec_hi, set_i, nmi_ack, force_brk});
    end
    checks++;
    if (vector !== 16'hFFFC || b_flag !== 1'b0) begin
      failures++; $display("FAIL reset_vec got=%h/%b exp=fffc/0", vector, b_flag);
    end
  endtask

  task automatic test_reset_seq();
    rst_n = 1'b1;
    sync = 1'b1;
    #1;
    checks++;
    if (force_brk !== 1'b1) begin failures++; $display("FAIL res_force_brk got=%b exp=1", force_brk); end
    push_exp(16'hFFFC, 1'b0, 1'b1, 1, 0);
    collect_seq(-1, 0);
    checks++;
    if (force_brk !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL res_no_replay got=%b/%b exp=0/0", force_brk, busy);
    end
    sync = 1'b0;
    cyc();
  endtask

  task automatic test_nmi();
    bit again;
    again = 0;
    nmi_n = 1'b0;
    repeat (3) cyc();
    sync = 1'b1;
    #1;
    checks++;
    if (force_brk !== 1'b1) begin failures++; $display("FAIL nmi_force_brk got=%b exp=1", force_brk); end
    push_exp(16'hFFFA, 1'b0, 1'b0, 1, 1);
    cyc();
    sync = 1'b0;
    collect_seq(-1, 0);
    sync = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (force_brk || busy) again = 1;
      cyc();
    end
    checks++;
    if (again) begin failures++; $display("FAIL nmi_level_retrigger got=1 exp=0"); end
    sync = 1'b0;
    nmi_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_irq();
    irq_n = 1'b0;
    i_flag = 1'b1;
    repeat (3) cyc();
    sync = 1'b1;
    #1;
    checks++;
    if (force_brk !== 1'b0) begin failures++; $display("FAIL irq_masked_force got=%b exp=0", force_brk); end
    cyc();
    sync = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL irq_masked_busy got=%b exp=0", busy); end
    i_flag = 1'b0;
    sync = 1'b1;
    #1;
    checks++;
    if (force_brk !== 1'b1) begin failures++; $display("FAIL irq_force_brk got=%b exp=1", force_brk); end
    push_exp(16'hFFFE, 1'b0, 1'b0, 1, 0);
    cyc();
    sync = 1'b0;
    irq_n = 1'b1;
    collect_seq(-1, 0);
    i_flag = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_brk();
    brk_op = 1'b1;
    #1;
    checks++;
    if (force_brk !== 1'b0) begin failures++; $display("FAIL brk_force got=%b exp=0", force_brk); end
    push_exp(16'hFFFE, 1'b1, 1'b0, 2, 0);
    cyc();
    brk_op = 1'b0;
    collect_seq(-1, 0);
  endtask

  task automatic test_brk_nmi_hijack();
    brk_op = 1'b1;
    nmi_n = 1'b0;
    push_exp(16'hFFFA, 1'b1, 1'b0, 2, 1);
    cyc();
    brk_op = 1'b0;
    collect_seq(-1, 0);
    nmi_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic start_irq();
    irq_n = 1'b0;
    i_flag = 1'b0;
    repeat (3) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    irq_n = 1'b1;
    i_flag = 1'b1;
  endtask

  task automatic test_rdy();
    int n5;
    push_exp(16'hFFFE, 1'b0, 1'b0, 1, 0);
    start_irq();
    collect_seq(5, 3);
    n5 = 0;
    foreach (trace[i]) if (trace[i] == 5) n5++;
    checks++;
    if (trace.size() != 9 || n5 != 4) begin
      failures++; $display("FAIL rdy_hold_t5 got=len%0d/t5x%0d exp=len9/t5x4", trace.size(), n5);
    end
    repeat (3) cyc();
    push_exp(16'hFFFE, 1'b0, 1'b0, 1, 0);
    start_irq();
    collect_seq(3, 2);
    checks++;
    if (trace.size() != 6) begin
      failures++; $display("FAIL rdy_push_advance got=len%0d exp=len6", trace.size());
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid_seq();
    int waited;
    waited = 0;
    start_irq();
    while (step !== 3'd4 && waited < 10) begin cyc(); waited++; end
    checks++;
    if (step !== 3'd4) begin failures++; $display("FAIL mid_reach_t4 got=%0d exp=4", step); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || step !== 3'd0 || rw !== 1'b1 || push_p !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ctrl got=%b/%0d/%b/%b exp=0/0/1/0", busy, step, rw, push_p);
    end
    checks++;
    if (vector !== 16'hFFFC || b_flag !== 1'b0) begin
      failures++; $display("FAIL mid_reset_vec got=%h/%b exp=fffc/0", vector, b_flag);
    end
    cyc();
    rst_n = 1'b1;
    sync = 1'b1;
    #1;
    checks++;
    if (force_brk !== 1'b1) begin failures++; $display("FAIL mid_replay_force got=%b exp=1", force_brk); end
    push_exp(16'hFFFC, 1'b0, 1'b1, 1, 0);
    cyc();
    sync = 1'b0;
    collect_seq(-1, 0);
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_nmi();
    test_irq();
    test_brk();
    test_brk_nmi_hijack();
    test_rdy();
    test_reset_mid_seq();
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Upstream companion to the decoder; owns the 6502 reset, NMI, IRQ and BRK entry sequences.
- Detects and prioritises interrupt sources and forces a BRK opcode at instruction boundaries.
- Steps the 7-cycle entry sequence: dummy, dummy, push PCH, push PCL, push P, vector lo, vector hi.
- The decoder and register file follow its strobes. It never drives the data bus.

Parameters:
- SYNC_STAGES, 2, flops in nmi_n/irq_n synchronisers (min 2).
- VEC_NMI, 16'hFFFA, NMI vector low-byte address.
- VEC_RES, 16'hFFFC, reset vector low-byte address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset.
- rdy  in  1  1 = advance; 0 = hold the current step. Ignored on push steps.
- nmi_n  in  1  async NMI pin, falling-edge triggered.
- irq_n  in  1  async IRQ pin, level triggered, active low.
- i_flag  in  1  interrupt-disable bit from processor status.
- sync  in  1  decoder opcode-fetch cycle (instruction boundary).
- brk_op  in  1  decoder has latched opcode 00 in T1.
- busy  out  1  sequence in progress (steps T1..T6).
- force_brk  out  1  substitute 8'h00 for the fetched opcode this cycle.
- step  out  3  current step, 0..6.
- push_pch  out  1  write-cycle strobe for step T2.
- push_pcl  out  1  write-cycle strobe for step T3.
- push_p  out  1  write-cycle strobe for step T4.
- rw  out  1  1 = read, 0 = write. Low only on push steps of a non-reset sequence.
- b_flag  out  1  B bit value for the pushed P: 1 for BRK, else 0.
- vec_lo  out  1  vector low-byte fetch strobe (T5).
- vec_hi  out  1  vector high-byte fetch strobe (T6).
- vector  out  16  address to drive during T5; T6 uses vector|1.
- set_i  out  1  one-cycle pulse at T6 completion: set the I flag.
- nmi_ack  out  1  one-cycle pulse when the NMI pending latch clears.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - res_pend=1, nmi_pend=0, step=0, busy=0, rw=1.
  - All strobes 0, vector=VEC_RES, b_flag=0.
  - Synchroniser flops = 1 (pins idle high).
- Source FSM states: IDLE, SEQ. The source register uses the pkg enum SRC_NONE/RES/NMI/IRQ/BRK.
- NMI edge detect: a synchronised nmi_n transition 1->0 sets nmi_pend. A held-low level does not retrigger.
- IRQ qualification: irq_q = synchronised !irq_n & !i_flag, sampled only on a sync cycle.
- Start condition: in IDLE on a sync cycle with rdy=1. Priority is res_pend > nmi_pend > irq_q.
  - If one of these is active: force_brk=1 that cycle, source latched, enter SEQ at step 1 next cycle.
  - brk_op in IDLE with no forced entry: enter SEQ with source BRK at step 2. T1 was consumed by the decoder.
- Step advance:
  - step increments every cycle in SEQ when rdy=1 or on a push step; otherwise it holds.
  - After T6 completes: return to IDLE, step=0, set_i pulse.
  - Source-specific clears at T6 completion: RES clears res_pend; NMI clears nmi_pend and pulses nmi_ack.
- Reset source: push steps keep rw=1. The push strobes still pulse so the stack pointer decrements by 3.
- NMI hijack: if nmi_pend rises at any step <= T4 of an IRQ/BRK sequence, vector switches to VEC_NMI from T5 on. The source becomes NMI; b_flag keeps its latched value.
- After T4, a new NMI stays pending and is serviced at the next boundary.
- vector is registered: it updates on entry and on hijack, and is stable through T5/T6.
- rst_n asserted mid-sequence: immediate return to reset values. The reset sequence replays after release.
- Simultaneous nmi edge and irq on the same sync: NMI wins; IRQ is re-evaluated at the next boundary.
- A new edge while nmi_pend=1 is absorbed (single latch).

Decomposition:
- Package int_seq_pkg holds:
  - the src_e enum: NONE, RES, NMI, IRQ, BRK;
  - localparam step indices T1..T6;
  - default vector constants.
- One sub-module, edge_sync: SYNC_STAGES-deep synchroniser with a falling-edge pulse output. Instantiated for nmi_n, and for irq_n with the edge output unused.

Test Plan:
- Release rst_n, hold sync=1, rdy=1:
  - force_brk on the first sync, then steps 1..6 with rw=1 throughout.
  - vector=FFFC; set_i pulses after T6; busy drops.
- nmi_n 1->0 held low, sync pulse, i_flag=1:
  - vector=FFFA, rw=0 on T2..T4, b_flag=0, nmi_ack=1 once.
  - No second sequence while nmi_n is still low.
- irq_n=0 with i_flag=1 -> no entry.
- irq_n=0 with i_flag=0 -> vector=FFFE, b_flag=0.
- brk_op=1 in IDLE -> sequence starts at step 2, b_flag=1, vector=FFFE.
- brk_op=1 with an NMI edge injected at T3 -> vector becomes FFFA at T5, b_flag stays 1, nmi_ack pulses.
- rdy=0 for 3 cycles:
  - At T5: step holds at 5 for 3 cycles.
  - At T3: step advances regardless.
- rst_n low at T4 of an IRQ sequence -> outputs return to reset values immediately. A full reset sequence follows release.
